pipe_hazard_tracker: RTL
========================

// Module: pipe_hazard_tracker
// PURPOSE
//  Parametrised hazard/forwarding controller for the N-stage integer pipeline. Keeps a shadow
//  pipeline of destination tags for every stage after ID, decides stall/bubble for the instruction
//  in ID, and produces registered forwarding selects for the EX stage. Generalises fixed 5-stage
//  forwarding/hazard logic to any depth, per-class result latency, flag (C/Z) dependencies and flush.
// PARAMETERS
//  REG_ID_W   3   register-id width
//  NSTAGE     3   tracked stages after ID (1=EX .. NSTAGE=WB); >=2
//  ALU_LAT    1   stage index whose output register first holds an ALU result
//  LOAD_LAT   2   same for loads; ALU_LAT <= LOAD_LAT < NSTAGE
//  FLAG_LAT   1   same for C/Z flags written by flag-setting ops
//  CNT_W      16  stall counter width
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          asynchronous, active-low reset
//  id_valid        in   1          ID holds a real instruction
//  id_rs1/id_rs2   in   REG_ID_W   source register ids
//  id_rs1_use/_rs2_use in 1        source actually read
//  id_rd           in   REG_ID_W   destination id
//  id_wen          in   1          instruction writes id_rd
//  id_is_load      in   1          result comes from data memory
//  id_sets_flags   in   1          writes C/Z
//  id_uses_flags   in   1          reads C (adc/sbc, conditional branch)
//  flush           in   1          squash instruction in ID (taken branch/jump resolved)
//  if_id_write_en  out  1          0 = hold IF/ID register
//  pc_write_en     out  1          0 = hold PC
//  ctrl_en         out  1          0 = zero control signals into ID/EX (bubble)
//  fwd_a/fwd_b     out  SELW       SELW=$clog2(NSTAGE+1); 0=RF, j=pipeline reg after stage j-1... see below
//  stall_count     out  CNT_W      saturating count of stall cycles
// BEHAVIOUR
//  - Shadow entry per stage k=1..NSTAGE: {valid, rd, wen, is_load, sets_flags}. Each clock: entry k
//    moves to k+1, entry NSTAGE retires; stage 1 loads the ID tag if issue, else a bubble (valid=0).
//  - issue = id_valid & ~stall & ~flush. Hit on source s: youngest k with valid&wen&rd==s, s used.
//  - Producer latency L = LOAD_LAT if is_load else ALU_LAT. Hit at k<L -> stall. Hit at k>=L and
//    k<NSTAGE -> next-cycle fwd = k+1 (value in output register of stage k+1). k==NSTAGE or no hit ->
//    fwd=0 (RF is write-first, same-cycle write visible). Only the youngest hit counts.
//  - Flag hazard: id_uses_flags & youngest sets_flags entry at k<FLAG_LAT -> stall; no flag forwarding.
//  - stall = id_valid & ~flush & (any source or flag hazard). Outputs combinational:
//    if_id_write_en=pc_write_en=~stall; ctrl_en=~(stall|flush).
//  - flush has priority over stall: ID squashed, PC/IF-ID advance, bubble enters stage 1.
//  - fwd_a/fwd_b registered: load computed value on issue, load 0 on stall/flush/bubble.
//  - stall_count += 1 each stall cycle, holds at 2^CNT_W-1.
//  - Reset (async, any time incl. mid-stall): all entries invalid, fwd_a=fwd_b=0, stall_count=0;
//    hence if_id_write_en=pc_write_en=ctrl_en=1 while reset is asserted.
// STRUCTURE
//  - pipe_pkg: typedef struct packed pipe_tag_t {valid, rd, wen, is_load, sets_flags}; fwd select width
//    function; latency defaults shared with the data path.
//  - Sub-module pipe_tag_shift: NSTAGE-deep pipe_tag_t shift register with bubble insert; hazard
//    compare, priority pick and counter stay in pipe_hazard_tracker.
// TESTING
//  - add r1; next add r2,r1,r3 (defaults) -> no stall, fwd_a=2 in EX cycle.
//  - lw r1; next add r2,r1,r1 -> 1 stall cycle (ctrl_en=0, pc_write_en=0), then fwd_a=fwd_b=3.
//  - writer r4 three instructions earlier (k=NSTAGE) -> fwd=0, no stall; r4 at k=2 & k=1 -> youngest (fwd=2).
//  - sub (sets_flags) then adc -> no stall with FLAG_LAT=1; rebuild with FLAG_LAT=2 -> exactly 1 stall.
//  - flush asserted during load-use stall -> ctrl_en=0, pc_write_en=1, stall_count unchanged.
//  - rst low mid-stall -> all outputs to reset values immediately; CNT_W=2, 5 stalls -> stall_count=3.

Source files
------------

// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared types and defaults for the integer-pipeline hazard tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_tracker_pkg;

    // Widest register id a shadow tag can carry; narrower ids are zero-extended.
    localparam int TAG_RD_W = 8;

    // Result-latency defaults, shared with the data path.
    localparam int DEF_REG_ID_W = 3;
    localparam int DEF_NSTAGE   = 3;
    localparam int DEF_ALU_LAT  = 1;
    localparam int DEF_LOAD_LAT = 2;
    localparam int DEF_FLAG_LAT = 1;
    localparam int DEF_CNT_W    = 16;

    // Destination tag carried alongside each instruction after ID.
    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                wen;
        logic                is_load;
        logic                sets_flags;
    } pipe_tag_t;

    // Forward select width: 0 = register file, 1..NSTAGE = pipeline registers.
    function automatic int fwd_sel_w(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_tag_shift.sv
// Shadow pipeline of destination tags, stage 1 (EX) .. NSTAGE (WB).
// Latency: 1 cycle per stage; the tag moves one stage every clock.
// Backpressure: none; a non-issued slot enters stage 1 as an invalid bubble.
module pipe_tag_shift
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  pipe_tag_t                in_tag,
    output pipe_tag_t [NSTAGE:1]     tags
);

    pipe_tag_t [NSTAGE:1] tag_q;

    // Advance every entry one stage; stage 1 takes the ID tag or a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
        end else begin
            tag_q[1] <= issue ? in_tag : '0;
            for (int k = 2; k <= NSTAGE; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tags = tag_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Stall/bubble decision for ID and registered EX forward selects for an N-stage pipeline.
// Latency: stall/enables combinational from ID; fwd_a/fwd_b valid one cycle after issue.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; flush overrides stall.
module pipe_hazard_tracker
    import pipe_hazard_tracker_pkg::*;
#(
    parameter int REG_ID_W = DEF_REG_ID_W,
    parameter int NSTAGE   = DEF_NSTAGE,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int FLAG_LAT = DEF_FLAG_LAT,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SELW     = fwd_sel_w(NSTAGE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_ID_W-1:0] id_rs1,
    input  logic [REG_ID_W-1:0] id_rs2,
    input  logic                id_rs1_use,
    input  logic                id_rs2_use,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic                id_wen,
    input  logic                id_is_load,
    input  logic                id_sets_flags,
    input  logic                id_uses_flags,
    input  logic                flush,
    output logic                if_id_write_en,
    output logic                pc_write_en,
    output logic                ctrl_en,
    output logic [SELW-1:0]     fwd_a,
    output logic [SELW-1:0]     fwd_b,
    output logic [CNT_W-1:0]    stall_count
);

    pipe_tag_t [NSTAGE:1] tags;
    pipe_tag_t            id_tag;
    logic [SELW:0]        pick_a;
    logic [SELW:0]        pick_b;
    logic                 flag_haz;
    logic                 stall;
    logic                 issue;

    // Scan oldest to youngest so the youngest matching producer decides.
    // Returns {hazard, select}; a producer still inside its latency stalls,
    // one that has produced is forwarded unless it is already writing back.
    function automatic logic [SELW:0] pick_src(
        input pipe_tag_t [NSTAGE:1] t,
        input logic                 used,
        input logic [REG_ID_W-1:0]  src
    );
        logic            haz;
        logic [SELW-1:0] sel;
        int              lat;
        haz = 1'b0;
        sel = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            lat = t[k].is_load ? LOAD_LAT : ALU_LAT;
            if (used && t[k].valid && t[k].wen && t[k].rd == TAG_RD_W'(src)) begin
                haz = (k < lat);
                sel = (k >= lat && k < NSTAGE) ? SELW'(k + 1) : '0;
            end
        end
        return {haz, sel};
    endfunction

    // Pack the ID instruction into the tag that will enter stage 1.
    always_comb begin
        id_tag            = '0;
        id_tag.valid      = 1'b1;
        id_tag.rd         = TAG_RD_W'(id_rd);
        id_tag.wen        = id_wen;
        id_tag.is_load    = id_is_load;
        id_tag.sets_flags = id_sets_flags;
    end

    pipe_tag_shift #(
        .NSTAGE (NSTAGE)
    ) u_tag_shift (
        .clk    (clk),
        .rst    (rst),
        .issue  (issue),
        .in_tag (id_tag),
        .tags   (tags)
    );

    // Source-register and flag hazard detection; flags are never forwarded.
    always_comb begin
        pick_a   = pick_src(tags, id_rs1_use, id_rs1);
        pick_b   = pick_src(tags, id_rs2_use, id_rs2);
        flag_haz = 1'b0;
        for (int k = 1; k <= NSTAGE; k++) begin
            if (k < FLAG_LAT && tags[k].valid && tags[k].sets_flags) begin
                flag_haz = 1'b1;
            end
        end
        flag_haz = flag_haz & id_uses_flags;
    end

    assign stall          = id_valid & ~flush & (pick_a[SELW] | pick_b[SELW] | flag_haz);
    assign issue          = id_valid & ~stall & ~flush;
    assign if_id_write_en = ~stall;
    assign pc_write_en    = ~stall;
    assign ctrl_en        = ~(stall | flush);

    // Forward selects follow the instruction into EX; bubbles read the RF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a <= '0;
            fwd_b <= '0;
        end else if (issue) begin
            fwd_a <= pick_a[SELW-1:0];
            fwd_b <= pick_b[SELW-1:0];
        end else begin
            fwd_a <= '0;
            fwd_b <= '0;
        end
    end

    // Saturating count of cycles spent stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && stall_count != {CNT_W{1'b1}}) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
